c_credit_tracker: RTL and testbench

Sender-side credit counter that sits directly upstream of a register-based FIFO on the far end of a link. It tracks how many FIFO slots are free by debiting one credit per flit sent (the FIFO's push) and crediting one back per FIFO pop, after a configurable return-path delay. It gates the sender so that the downstream FIFO can never overflow, and reports underflow and overflow of the credit protocol.

---
 rtl/c_credit_tracker.sv | 97 +++++++++
 tb/tb_c_credit_tracker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/c_credit_tracker.sv
// Sender-side credit counter guarding a downstream register FIFO.
// Sticky error flags are built only with C_CREDIT_TRACKER_ERROR_CHECK_EN.
module c_credit_tracker #(
    parameter int num_credits  = 4,
    parameter int credit_delay = 2,
    localparam int cw = $clog2(num_credits + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          debit,
    input  logic          credit,
    output logic [cw-1:0] credit_count,
    output logic          credit_avail,
    output logic          almost_empty,
    output logic          all_credits,
    output logic [1:0]    errors
);

    localparam logic [cw-1:0] full = cw'(num_credits);

    logic          arrive;
    logic          pipe_empty;
    logic [cw-1:0] count_q, count_d;
    logic [cw-1:0] count_eff;
    logic          dec;
    logic          inc;

    generate
        if (credit_delay == 0) begin : g_nopipe
            assign arrive     = credit;
            assign pipe_empty = 1'b1;
        end else begin : g_pipe
            localparam int pw = $clog2(credit_delay + 1);
            logic [credit_delay-1:0] pipe_q, pipe_d;
            logic [pw-1:0]           inflight_q, inflight_d;

            always_comb begin
                pipe_d    = pipe_q << 1;
                pipe_d[0] = credit;
                inflight_d = inflight_q + pw'(credit) - pw'(arrive);
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    pipe_q     <= '0;
                    inflight_q <= '0;
                end else begin
                    pipe_q     <= pipe_d;
                    inflight_q <= inflight_d;
                end
            end

            assign arrive     = pipe_q[credit_delay-1];
            assign pipe_empty = (inflight_q == '0);
        end
    endgenerate

    // A debit at zero is refused; an arrival is dropped once full.
    always_comb begin
        dec       = debit && (count_q != '0);
        count_eff = count_q - cw'(dec);
        inc       = arrive && (count_eff != full);
        count_d   = count_eff + cw'(inc);
    end

    always_ff @(posedge clk) begin
        if (!reset) count_q <= full;
        else        count_q <= count_d;
    end

    assign credit_count = count_q;
    assign credit_avail = (count_q != '0);
    assign almost_empty = (count_q == cw'(1));
    assign all_credits  = (count_q == full) && pipe_empty;

`ifdef C_CREDIT_TRACKER_ERROR_CHECK_EN
    logic [1:0] err_q, err_d;
    logic       underflow;
    logic       overflow;

    always_comb begin
        underflow = debit && (count_q == '0);
        overflow  = arrive && (count_q == full) && !debit;
        err_d     = err_q | {overflow, underflow};
    end

    always_ff @(posedge clk) begin
        if (!reset) err_q <= 2'b00;
        else        err_q <= err_d;
    end

    assign errors = err_q;
`else
    assign errors = 2'b00;
`endif

endmodule

// File: tb/tb_c_credit_tracker.sv
// Directed plus random stimulus for c_credit_tracker against a
// queue-based model of in-flight credits.
module tb_c_credit_tracker;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          reset;
    logic          debit;
    logic          credit;
    logic [CW-1:0] credit_count;
    logic          credit_avail;
    logic          almost_empty;
    logic          all_credits;
    logic [1:0]    errors;

    int total;
    int bad;

    // model state: usable credits, due edges of returning credits, sticky errors
    int         m_cnt;
    int         m_due[$];
    int         m_edge;
    logic [1:0] m_err;

    c_credit_tracker #(
        .num_credits (N),
        .credit_delay(D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .debit       (debit),
        .credit      (credit),
        .credit_count(credit_count),
        .credit_avail(credit_avail),
        .almost_empty(almost_empty),
        .all_credits (all_credits),
        .errors      (errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input logic r, input logic d, input logic c);
        logic arr;
        if (!r) begin
            m_cnt = N;
            m_due.delete();
            m_err = 2'b00;
        end else begin
            if (c) m_due.push_back(m_edge + D);
            arr = 1'b0;
            if (m_due.size() > 0 && m_due[0] == m_edge) begin
                arr = 1'b1;
                void'(m_due.pop_front());
            end
            if (d && m_cnt == 0) m_err[0] = 1'b1;
            if (arr && !d && m_cnt == N) m_err[1] = 1'b1;
            if (d && m_cnt > 0) m_cnt = m_cnt - 1;
            if (arr && m_cnt < N) m_cnt = m_cnt + 1;
        end
        m_edge++;
    endtask

    task automatic check(input string tag);
        logic [1:0] exp_err;
`ifdef C_CREDIT_TRACKER_ERROR_CHECK_EN
        exp_err = m_err;
`else
        exp_err = 2'b00;
`endif
        total++;
        assert (credit_count === CW'(m_cnt)) else begin
            bad++;
            $error("FAIL %s count got=%0d exp=%0d", tag, credit_count, m_cnt);
        end
        total++;
        assert (credit_avail === (m_cnt != 0)) else begin
            bad++;
            $error("FAIL %s avail got=%b exp=%b", tag, credit_avail, m_cnt != 0);
        end
        total++;
        assert (almost_empty === (m_cnt == 1)) else begin
            bad++;
            $error("FAIL %s almost got=%b exp=%b", tag, almost_empty, m_cnt == 1);
        end
        total++;
        assert (all_credits === (m_cnt == N && m_due.size() == 0)) else begin
            bad++;
            $error("FAIL %s all got=%b exp=%b", tag, all_credits,
                   m_cnt == N && m_due.size() == 0);
        end
        total++;
        assert (errors === exp_err) else begin
            bad++;
            $error("FAIL %s errors got=%b exp=%b", tag, errors, exp_err);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic d, input logic c);
        reset  = r;
        debit  = d;
        credit = c;
        @(posedge clk);
        model_edge(r, d, c);
        #1;
        check(tag);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        m_cnt  = N;
        m_edge = 0;
        m_err  = 2'b00;
        reset  = 1'b0;
        debit  = 1'b0;
        credit = 1'b0;

        step("reset", 1'b0, 1'b0, 1'b0);
        step("idle", 1'b1, 1'b0, 1'b0);
        total++;
        assert (credit_count === CW'(N)) else begin
            bad++;
            $error("FAIL reset_const count got=%0d exp=%0d", credit_count, N);
        end

        for (int i = 0; i < 4; i++) step("drain", 1'b1, 1'b1, 1'b0);
        total++;
        assert (credit_avail === 1'b0) else begin
            bad++;
            $error("FAIL drained avail got=%b exp=0", credit_avail);
        end

        step("pop0", 1'b1, 1'b0, 1'b1);
        step("wait1", 1'b1, 1'b0, 1'b0);
        step("arr1", 1'b1, 1'b0, 1'b0);
        total++;
        assert (credit_count === CW'(1)) else begin
            bad++;
            $error("FAIL late_arrive count got=%0d exp=1", credit_count);
        end

        step("pop1", 1'b1, 1'b0, 1'b1);
        step("pop2", 1'b1, 1'b0, 1'b1);
        step("arr2", 1'b1, 1'b0, 1'b0);
        step("deb_arr", 1'b1, 1'b1, 1'b0);
        step("settle", 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 2; i++) step("to0", 1'b1, 1'b1, 1'b0);
        step("pop_z", 1'b1, 1'b0, 1'b1);
        step("wait_z", 1'b1, 1'b0, 1'b0);
        step("uf_arr", 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) step("refill", 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("drain2", 1'b1, 1'b0, 1'b0);
        step("ovf", 1'b1, 1'b0, 1'b1);
        step("ovf_w", 1'b1, 1'b0, 1'b0);
        step("ovf_a", 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b1, 1'b0);
        step("pipe1", 1'b1, 1'b0, 1'b1);
        step("pipe2", 1'b1, 1'b0, 1'b1);
        step("rst_mid", 1'b0, 1'b0, 1'b0);
        step("no_late1", 1'b1, 1'b0, 1'b0);
        step("no_late2", 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 9) < 5),
                 ($urandom_range(0, 9) < 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
